// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: one full-subtract cell stepped LSB first over
// WIDTH cycles, with start/busy/done handshake and held result registers.
module subtrator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out
);

    // state   | meaning
    // IDLE    | waiting for i_start, result registers hold last value
    // SUB     | one bit per cycle through the subtract cell
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Upper WIDTH-1 bits of the difference shift register; the bit leaving
    // at the LSB end is never needed, so it is not stored.
    logic [WIDTH-2:0] r_d;
    logic             r_bflop;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_shift;

    assign w_d     = r_a[0] ^ r_b[0] ^ r_bflop;
    assign w_bout  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bflop);
    assign w_shift = {w_d, r_d};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_d          <= '0;
            r_bflop      <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_d     <= '0;
                        r_bflop <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_d     <= w_shift[WIDTH-1:1];
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + 1'b1;
                    // Results are only published here, so no partial value leaks out.
                    if (r_cnt == LAST_BIT) begin
                        r_diff       <= w_shift;
                        r_borrow_out <= w_bout;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow_out;

endmodule

// File: tb/tb_subtrator_serial.sv
// Bench for subtrator_serial (WIDTH=8): directed cases with literal results
// plus a randomized run compared every cycle against a timing/arithmetic model.
module tb_subtrator_serial;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    subtrator_serial #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_a          (a),
        .i_b          (b),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted op occupies W+1 cycles (W busy, then 1 done);
    // results are (a-b) mod 256 and a<b, published on entering the done cycle.
    int           m_rem = 0;
    int           m_ops = 0;
    logic [W-1:0] m_pdiff = '0;
    logic         m_pbor = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_bor = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_diff = '0;
            m_bor  = 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem   = W + 1;
                m_pdiff = a - b;
                m_pbor  = (a < b);
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 1) begin
                m_diff = m_pdiff;
                m_bor  = m_pbor;
                m_ops  = m_ops + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, m_rem >= 2});
            chk("done", {31'b0, done}, {31'b0, m_rem == 1});
            chk("diff", {24'b0, diff}, {24'b0, m_diff});
            chk("borrow_out", {31'b0, borrow_out}, {31'b0, m_bor});
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (m_rem != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wait idle timeout", {31'b0, m_rem == 0}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int n;
        int bc;
        wait_idle();
        a = ta;
        b = tb_in;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 32'd9);
        chk({nm, " busy cycles"}, bc, 32'd8);
        chk({nm, " diff"}, {24'b0, diff}, {24'b0, ed});
        chk({nm, " borrow"}, {31'b0, borrow_out}, {31'b0, eb});
    endtask

    initial begin
        int tgt;
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // reset held two edges while start toggles
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        start  = 1'b1;
        a      = 8'd9;
        b      = 8'd4;
        @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst diff", {24'b0, diff}, 32'd0);
        chk("rst borrow", {31'b0, borrow_out}, 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("post rst done", {31'b0, done}, 32'd0);

        run_op(8'd200, 8'd55, 8'd145, 1'b0, "200-55");
        run_op(8'd5, 8'd9, 8'd252, 1'b1, "5-9");
        run_op(8'd0, 8'd1, 8'd255, 1'b1, "0-1");
        run_op(8'd170, 8'd170, 8'd0, 1'b0, "170-170");
        run_op(8'd0, 8'd0, 8'd0, 1'b0, "0-0");
        run_op(8'd255, 8'd0, 8'd255, 1'b0, "255-0");

        // start held high, operands changing mid-op
        wait_idle();
        a = 8'd100;
        b = 8'd1;
        start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 9) begin
                chk("held done", {31'b0, done}, 32'd1);
                chk("held diff", {24'b0, diff}, 32'd99);
            end
            if (n < 10) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                chk("held idle busy", {31'b0, busy}, 32'd0);
                chk("held idle done", {31'b0, done}, 32'd0);
                a = 8'd50;
                b = 8'd20;
            end
        end
        @(negedge clk);
        chk("held reaccept busy", {31'b0, busy}, 32'd1);
        start = 1'b0;
        begin
            int k = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("held second diff", {24'b0, diff}, 32'd30);
        chk("held second borrow", {31'b0, borrow_out}, 32'd0);

        // reset in the middle of an op
        wait_idle();
        a = 8'd3;
        b = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst diff", {24'b0, diff}, 32'd0);
        chk("midrst borrow", {31'b0, borrow_out}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'd3, 8'd7, 8'd252, 1'b1, "3-7 after rst");

        // random traffic
        tgt = m_ops + 1000;
        cyc = 0;
        while (m_ops < tgt && cyc < 40000) begin
            @(negedge clk);
            start = ($urandom % 3) != 0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            rst   = ($urandom % 400) == 0;
            cyc++;
        end
        chk("random ops completed", {31'b0, m_ops >= tgt}, 32'd1);
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
